// File: rtl/id_pipe_if.sv
// Decode-stage signal bundle: if_id instruction, regfile read ports, EX/MEM forwarding
// sources, ctrl stall/flush, and the registered ID/EX outputs toward ex.
interface id_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               stall_i;
    logic               flush_i;
    logic [DATA_W-1:0]  pc_i;
    logic [31:0]        inst_i;
    logic [DATA_W-1:0]  reg1_data_i;
    logic [DATA_W-1:0]  reg2_data_i;
    logic               ex_wreg_i;
    logic [RADDR_W-1:0] ex_wd_i;
    logic [DATA_W-1:0]  ex_wdata_i;
    logic               ex_is_load_i;
    logic               mem_wreg_i;
    logic [RADDR_W-1:0] mem_wd_i;
    logic [DATA_W-1:0]  mem_wdata_i;

    logic               reg1_read_o;
    logic               reg2_read_o;
    logic [RADDR_W-1:0] reg1_addr_o;
    logic [RADDR_W-1:0] reg2_addr_o;
    logic               stallreq_o;
    logic [7:0]         ex_aluop_o;
    logic [2:0]         ex_alusel_o;
    logic [DATA_W-1:0]  ex_reg1_o;
    logic [DATA_W-1:0]  ex_reg2_o;
    logic [RADDR_W-1:0] ex_wd_o;
    logic               ex_wreg_o;
    logic [DATA_W-1:0]  ex_pc_o;
    logic               ex_valid_o;
    logic               ex_inst_inv_o;

    modport master (
        output stall_i, flush_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
               mem_wreg_i, mem_wd_i, mem_wdata_i,
        input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
               ex_pc_o, ex_valid_o, ex_inst_inv_o
    );

    modport slave (
        input  stall_i, flush_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
               mem_wreg_i, mem_wd_i, mem_wdata_i,
        output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
               ex_pc_o, ex_valid_o, ex_inst_inv_o
    );
endinterface

// File: rtl/id_pipe.sv
// MIPS32-subset decode with EX/MEM forwarding into a registered ID/EX stage (1-cycle latency);
// load-use hazards bubble ID/EX and hold if_id via stallreq_o, ctrl stall freezes ID/EX.
module id_pipe #(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter bit FWD_EX_EN   = 1'b1,
    parameter bit FWD_MEM_EN  = 1'b1,
    parameter bit LU_STALL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    id_pipe_if.slave  bus
);
    localparam logic [7:0] OP_NOP  = 8'h00, OP_OR    = 8'h25, OP_ANDI  = 8'h59, OP_ORI   = 8'h5A,
                           OP_XORI = 8'h5B, OP_SLL   = 8'h7C, OP_SLTI  = 8'h57, OP_SLTIU = 8'h58,
                           OP_ADDI = 8'h55, OP_ADDIU = 8'h56, OP_CLZ   = 8'hB0, OP_CLO   = 8'hB1,
                           OP_MUL  = 8'hA9, OP_MADD  = 8'hA6, OP_MADDU = 8'hA8, OP_MSUB  = 8'hAA,
                           OP_MSUBU = 8'hAB;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3,
                           SEL_ARITH = 3'd4, SEL_MUL = 3'd5;

    typedef struct packed {
        logic [7:0]         aluop;
        logic [2:0]         alusel;
        logic [DATA_W-1:0]  reg1;
        logic [DATA_W-1:0]  reg2;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  pc;
        logic               valid;
        logic               inv;
    } idex_t;

    logic [5:0]         opc, func;
    logic [4:0]         sa;
    logic [RADDR_W-1:0] rs_a, rt_a, rd_a;
    logic [7:0]         aluop;
    logic [2:0]         alusel;
    logic [RADDR_W-1:0] wd;
    logic               wreg, rd1, rd2, inv, movn, movz;
    logic [DATA_W-1:0]  imm, op1, op2;
    logic               ex_hit1, ex_hit2, mem_hit1, mem_hit2, wreg_f, lu_hit;
    idex_t              idex_d, idex_q;

    assign opc  = bus.inst_i[31:26];
    assign func = bus.inst_i[5:0];
    assign sa   = bus.inst_i[10:6];
    assign rs_a = RADDR_W'(bus.inst_i[25:21]);
    assign rt_a = RADDR_W'(bus.inst_i[20:16]);
    assign rd_a = RADDR_W'(bus.inst_i[15:11]);

    always_comb begin
        aluop = OP_NOP; alusel = SEL_NOP; wd = rd_a; wreg = 1'b0;
        rd1 = 1'b0; rd2 = 1'b0; imm = '0; inv = 1'b1; movn = 1'b0; movz = 1'b0;
        case (opc)
            6'h00: begin
                if (sa == 5'd0) begin
                    // SPECIAL aluop codes are the function field zero-extended
                    inv = 1'b0; aluop = {2'b00, func};
                    case (func)
                        6'h24, 6'h25, 6'h26, 6'h27: begin alusel = SEL_LOGIC; rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; end
                        6'h04, 6'h06, 6'h07:        begin alusel = SEL_SHIFT; rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; end
                        6'h0F:                      aluop = OP_NOP;
                        6'h0A, 6'h0B:               begin alusel = SEL_MOVE; rd1 = 1'b1; rd2 = 1'b1;
                                                          movn = func[0]; movz = ~func[0]; end
                        6'h10, 6'h12:               begin alusel = SEL_MOVE; wreg = 1'b1; end
                        6'h11, 6'h13:               rd1 = 1'b1;
                        6'h20, 6'h21, 6'h22, 6'h23,
                        6'h2A, 6'h2B:               begin alusel = SEL_ARITH; rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; end
                        6'h18, 6'h19:               begin rd1 = 1'b1; rd2 = 1'b1; end
                        default:                    begin aluop = OP_NOP; inv = 1'b1; end
                    endcase
                end
                if (bus.inst_i[31:21] == 11'd0 && (func == 6'h00 || func == 6'h02 || func == 6'h03)) begin
                    inv = 1'b0; aluop = (func == 6'h00) ? OP_SLL : {2'b00, func};
                    alusel = SEL_SHIFT; rd2 = 1'b1; imm = DATA_W'(sa); wreg = 1'b1;
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                inv = 1'b0; alusel = SEL_LOGIC; rd1 = 1'b1; wd = rt_a; wreg = 1'b1;
                imm = DATA_W'(bus.inst_i[15:0]);
                aluop = (opc == 6'h0C) ? OP_ANDI : (opc == 6'h0D) ? OP_ORI : OP_XORI;
            end
            6'h0F: begin
                inv = 1'b0; aluop = OP_OR; alusel = SEL_LOGIC; rd1 = 1'b1; wd = rt_a; wreg = 1'b1;
                imm = DATA_W'({bus.inst_i[15:0], 16'h0000});
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                inv = 1'b0; alusel = SEL_ARITH; rd1 = 1'b1; wd = rt_a; wreg = 1'b1;
                imm = {{(DATA_W-16){bus.inst_i[15]}}, bus.inst_i[15:0]};
                aluop = (opc == 6'h08) ? OP_ADDI : (opc == 6'h09) ? OP_ADDIU :
                        (opc == 6'h0A) ? OP_SLTI : OP_SLTIU;
            end
            6'h33: inv = 1'b0;
            6'h1C: begin
                inv = 1'b0;
                case (func)
                    6'h20:   begin aluop = OP_CLZ; alusel = SEL_ARITH; rd1 = 1'b1; wreg = 1'b1; end
                    6'h21:   begin aluop = OP_CLO; alusel = SEL_ARITH; rd1 = 1'b1; wreg = 1'b1; end
                    6'h02:   begin aluop = OP_MUL; alusel = SEL_MUL; rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; end
                    6'h00:   begin aluop = OP_MADD;  rd1 = 1'b1; rd2 = 1'b1; end
                    6'h01:   begin aluop = OP_MADDU; rd1 = 1'b1; rd2 = 1'b1; end
                    6'h04:   begin aluop = OP_MSUB;  rd1 = 1'b1; rd2 = 1'b1; end
                    6'h05:   begin aluop = OP_MSUBU; rd1 = 1'b1; rd2 = 1'b1; end
                    default: inv = 1'b1;
                endcase
            end
            default: inv = 1'b1;
        endcase
    end

    // EX result is younger than MEM, so it wins when both target the same register
    assign ex_hit1  = FWD_EX_EN  && bus.ex_wreg_i  && (bus.ex_wd_i  == rs_a);
    assign ex_hit2  = FWD_EX_EN  && bus.ex_wreg_i  && (bus.ex_wd_i  == rt_a);
    assign mem_hit1 = FWD_MEM_EN && bus.mem_wreg_i && (bus.mem_wd_i == rs_a);
    assign mem_hit2 = FWD_MEM_EN && bus.mem_wreg_i && (bus.mem_wd_i == rt_a);

    assign op1 = !rd1 ? imm : (rs_a == '0) ? '0 : ex_hit1 ? bus.ex_wdata_i :
                 mem_hit1 ? bus.mem_wdata_i : bus.reg1_data_i;
    assign op2 = !rd2 ? imm : (rt_a == '0) ? '0 : ex_hit2 ? bus.ex_wdata_i :
                 mem_hit2 ? bus.mem_wdata_i : bus.reg2_data_i;

    assign wreg_f = movn ? (op2 != '0) : movz ? (op2 == '0) : wreg;

    assign lu_hit = LU_STALL_EN && bus.ex_is_load_i && bus.ex_wreg_i && (bus.ex_wd_i != '0) &&
                    ((rd1 && bus.ex_wd_i == rs_a) || (rd2 && bus.ex_wd_i == rt_a));

    assign bus.reg1_read_o = rst & rd1;
    assign bus.reg2_read_o = rst & rd2;
    assign bus.reg1_addr_o = rst ? rs_a : '0;
    assign bus.reg2_addr_o = rst ? rt_a : '0;
    assign bus.stallreq_o  = rst & lu_hit;

    assign idex_d = '{aluop: aluop, alusel: alusel, reg1: op1, reg2: op2, wd: wd,
                      wreg: wreg_f, pc: bus.pc_i, valid: 1'b1, inv: inv};

    // A bubble is the all-zero record: NOP codes are zero by encoding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               idex_q <= '0;
        else if (bus.flush_i)   idex_q <= '0;
        else if (bus.stall_i)   idex_q <= idex_q;
        else if (lu_hit)        idex_q <= '0;
        else                    idex_q <= idex_d;
    end

    assign bus.ex_aluop_o    = idex_q.aluop;
    assign bus.ex_alusel_o   = idex_q.alusel;
    assign bus.ex_reg1_o     = idex_q.reg1;
    assign bus.ex_reg2_o     = idex_q.reg2;
    assign bus.ex_wd_o       = idex_q.wd;
    assign bus.ex_wreg_o     = idex_q.wreg;
    assign bus.ex_pc_o       = idex_q.pc;
    assign bus.ex_valid_o    = idex_q.valid;
    assign bus.ex_inst_inv_o = idex_q.inv;
endmodule

// File: tb/tb_id_pipe.sv
// Scoreboarded bench for id_pipe: directed instructions push expected ID/EX contents,
// a monitor compares them one cycle later just after the capturing clock edge.
module tb_id_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_pipe_if bus ();
    id_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        logic        valid;
        logic        inv;
        logic        stq;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    failures = 0;

    function automatic exp_t mk(input logic [7:0] aluop, input logic [2:0] alusel,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                                input logic wreg, input logic [31:0] pc, input logic inv,
                                input logic stq);
        exp_t e;
        e.aluop = aluop; e.alusel = alusel; e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wreg;
        e.pc = pc; e.valid = 1'b1; e.inv = inv; e.stq = stq;
        return e;
    endfunction

    function automatic exp_t bub(input logic stq);
        exp_t e;
        e = '0;
        e.stq = stq;
        return e;
    endfunction

    function automatic exp_t act();
        exp_t e;
        e.aluop = bus.ex_aluop_o; e.alusel = bus.ex_alusel_o; e.r1 = bus.ex_reg1_o;
        e.r2 = bus.ex_reg2_o; e.wd = bus.ex_wd_o; e.wreg = bus.ex_wreg_o; e.pc = bus.ex_pc_o;
        e.valid = bus.ex_valid_o; e.inv = bus.ex_inst_inv_o; e.stq = bus.stallreq_o;
        return e;
    endfunction

    task automatic chkv(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drv(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
        bus.inst_i = inst; bus.pc_i = pc; bus.reg1_data_i = d1; bus.reg2_data_i = d2;
    endtask

    task automatic fwd(input logic ew, input logic [4:0] ewd, input logic [31:0] edat,
                       input logic ld, input logic mw, input logic [4:0] mwd,
                       input logic [31:0] mdat);
        bus.ex_wreg_i = ew; bus.ex_wd_i = ewd; bus.ex_wdata_i = edat; bus.ex_is_load_i = ld;
        bus.mem_wreg_i = mw; bus.mem_wd_i = mwd; bus.mem_wdata_i = mdat;
    endtask

    task automatic issue(input string name, input exp_t e);
        q.push_back(e);
        nq.push_back(name);
        @(negedge clk);
    endtask

    // Monitor: one expectation per captured cycle, sampled just after the rising edge
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n = nq.pop_front();
                chkv(n, 128'(act()), 128'(e));
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        drv(32'h0000_0000, 32'h0, 32'h0, 32'h0);
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        chkv("reset_state", 128'(act()), 128'(bub(1'b0)));
        chkv("reset_comb", 128'({bus.reg1_read_o, bus.reg2_read_o, bus.reg1_addr_o,
                                 bus.reg2_addr_o, bus.stallreq_o}), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // ori $1,$0,0x1234
        drv(32'h3401_1234, 32'h100, 32'hDEAD, 32'hBEEF);
        issue("ori_imm", mk(8'h5A, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 32'h100, 1'b0, 1'b0));
        // or $4,$3,$3 with EX and MEM both writing $3
        drv(32'h0063_2025, 32'h104, 32'h11, 32'h22);
        fwd(1'b1, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd3, 32'hBB);
        issue("fwd_ex_over_mem", mk(8'h25, 3'd1, 32'hAA, 32'hAA, 5'd4, 1'b1, 32'h104, 1'b0, 1'b0));
        fwd(1'b0, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd3, 32'hBB);
        drv(32'h0063_2025, 32'h108, 32'h11, 32'h22);
        issue("fwd_mem", mk(8'h25, 3'd1, 32'hBB, 32'hBB, 5'd4, 1'b1, 32'h108, 1'b0, 1'b0));
        // add $5,$0,$0 while EX claims to write r0
        drv(32'h0000_2820, 32'h10C, 32'h77, 32'h77);
        fwd(1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0);
        issue("r0_no_fwd", mk(8'h20, 3'd4, 32'h0, 32'h0, 5'd5, 1'b1, 32'h10C, 1'b0, 1'b0));
        // addu $6,$2,$7 behind a load to $2
        drv(32'h0047_3021, 32'h110, 32'h10, 32'h20);
        fwd(1'b1, 5'd2, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        issue("load_use_bubble", bub(1'b1));
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        issue("load_use_retry", mk(8'h21, 3'd4, 32'h10, 32'h20, 5'd6, 1'b1, 32'h110, 1'b0, 1'b0));
        // ctrl stall holds ID/EX while a different instruction waits
        bus.stall_i = 1'b1;
        drv(32'h3401_1234, 32'h114, 32'h0, 32'h0);
        issue("stall_hold1", mk(8'h21, 3'd4, 32'h10, 32'h20, 5'd6, 1'b1, 32'h110, 1'b0, 1'b0));
        issue("stall_hold2", mk(8'h21, 3'd4, 32'h10, 32'h20, 5'd6, 1'b1, 32'h110, 1'b0, 1'b0));
        bus.flush_i = 1'b1;
        drv(32'h3401_1234, 32'h118, 32'h0, 32'h0);
        issue("flush_over_stall", bub(1'b0));
        bus.flush_i = 1'b0; bus.stall_i = 1'b0;
        drv(32'hFC00_0000, 32'h11C, 32'h1, 32'h2);
        issue("invalid_inst", mk(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h11C, 1'b1, 1'b0));
        // movn/movz $8,$9,$10 with rt forwarded from EX (regfile copy is zero)
        drv(32'h012A_400B, 32'h120, 32'h33, 32'h0);
        fwd(1'b1, 5'd10, 32'h5, 1'b0, 1'b0, 5'd0, 32'h0);
        issue("movn_fwd", mk(8'h0B, 3'd3, 32'h33, 32'h5, 5'd8, 1'b1, 32'h120, 1'b0, 1'b0));
        drv(32'h012A_400A, 32'h124, 32'h33, 32'h0);
        issue("movz_fwd", mk(8'h0A, 3'd3, 32'h33, 32'h5, 5'd8, 1'b0, 32'h124, 1'b0, 1'b0));
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        // sll $2,$3,4
        drv(32'h0003_1100, 32'h128, 32'h44, 32'h99);
        issue("sll_sa", mk(8'h7C, 3'd2, 32'h4, 32'h99, 5'd2, 1'b1, 32'h128, 1'b0, 1'b0));
        // addi $3,$1,-1
        drv(32'h2023_FFFF, 32'h12C, 32'h7, 32'h0);
        issue("addi_sext", mk(8'h55, 3'd4, 32'h7, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h12C, 1'b0, 1'b0));
        // lui $7,0xABCD
        drv(32'h3C07_ABCD, 32'h130, 32'h7, 32'h0);
        issue("lui", mk(8'h25, 3'd1, 32'h0, 32'hABCD_0000, 5'd7, 1'b1, 32'h130, 1'b0, 1'b0));

        // Asynchronous reset during a stall with a load-use hazard on the inputs
        bus.stall_i = 1'b1;
        drv(32'h0047_3021, 32'h140, 32'h10, 32'h20);
        fwd(1'b1, 5'd2, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        chkv("async_reset", 128'(act()), 128'(bub(1'b0)));
        chkv("reset_comb_mid", 128'({bus.reg1_read_o, bus.reg2_read_o, bus.reg1_addr_o,
                                     bus.reg2_addr_o, bus.stallreq_o}), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        issue("reset_discards_held", bub(1'b1));
        bus.stall_i = 1'b0;
        fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        drv(32'h3401_1234, 32'h204, 32'h0, 32'h0);
        issue("post_reset_ori", mk(8'h5A, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 32'h204, 1'b0, 1'b0));

        repeat (2) @(negedge clk);
        chkv("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
